// File: rtl/core_avl_arbiter_if.sv
// Avalon-MM command/response bundle shared by the arbiter's master and slave sides.
// The master modport belongs to whoever issues commands; the slave modport to whoever answers them.
interface core_avl_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   address;
  logic [DATA_W/8-1:0] byte_enable;
  logic                read;
  logic                write;
  logic [DATA_W-1:0]   write_data;
  logic                waitrequest;
  logic [DATA_W-1:0]   read_data;
  logic                read_data_valid;

  modport master (
    output address, byte_enable, read, write, write_data,
    input  waitrequest, read_data, read_data_valid
  );

  modport slave (
    input  address, byte_enable, read, write, write_data,
    output waitrequest, read_data, read_data_valid
  );
endinterface

// File: rtl/core_avl_arbiter.sv
// Two-master to one-slave Avalon-MM arbiter for the core memory bus.
// Master 0 is the load/store unit and master 1 is instruction fetch.
// Grant is decided combinationally and held while the slave stalls a command.
// Accepted reads record their master ID in a small FIFO so that in-order
// responses can be routed back to whoever issued them.
// Optional feature macro: CORE_AVL_ARB_RR_EN selects round-robin arbitration;
// without it m0 has fixed priority over m1.
module core_avl_arbiter #(
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                     clk,
  input  logic                     rest,
  core_avl_arbiter_if.slave        m0,
  core_avl_arbiter_if.slave        m1,
  core_avl_arbiter_if.master       s,
  output logic                     err_rvalid_unexp
);

  localparam int PTR_W = $clog2(MAX_OUTSTANDING);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {
    ST_IDLE,
    ST_LOCKED
  } state_t;

  state_t              r_state;
  state_t              w_nextState;
  logic                r_owner;
  logic                w_nextOwner;

  logic                r_idFifo [MAX_OUTSTANDING];
  logic [PTR_W-1:0]    r_wrPtr;
  logic [PTR_W-1:0]    r_rdPtr;
  logic [CNT_W-1:0]    r_rdCnt;
  logic                r_err;

  logic                w_req0;
  logic                w_req1;
  logic                w_grantValid;
  logic                w_grant;

  logic [ADDR_W-1:0]   w_gAddress;
  logic [DATA_W/8-1:0] w_gByteEnable;
  logic                w_gRead;
  logic                w_gWrite;
  logic [DATA_W-1:0]   w_gWriteData;

  logic                w_rdBlock;
  logic                w_accept;
  logic                w_push;
  logic                w_pop;
  logic                w_cntNonZero;
  logic                w_headId;

`ifdef CORE_AVL_ARB_RR_EN
  logic                r_last;
`endif

  assign w_req0 = m0.read | m0.write;
  assign w_req1 = m1.read | m1.write;

  // Grant selection: a locked owner keeps the bus, otherwise arbitrate current requests.
  always_comb begin
    w_grantValid = 1'b0;
    w_grant      = 1'b0;
    if (r_state == ST_LOCKED) begin
      w_grantValid = 1'b1;
      w_grant      = r_owner;
    end else if (w_req0 && w_req1) begin
      w_grantValid = 1'b1;
`ifdef CORE_AVL_ARB_RR_EN
      w_grant      = ~r_last;
`else
      w_grant      = 1'b0;
`endif
    end else if (w_req0) begin
      w_grantValid = 1'b1;
      w_grant      = 1'b0;
    end else if (w_req1) begin
      w_grantValid = 1'b1;
      w_grant      = 1'b1;
    end
  end

  // Command mux: forward the granted master's fields, all zero when nobody holds the grant.
  always_comb begin
    w_gAddress    = '0;
    w_gByteEnable = '0;
    w_gRead       = 1'b0;
    w_gWrite      = 1'b0;
    w_gWriteData  = '0;
    if (w_grantValid) begin
      if (w_grant) begin
        w_gAddress    = m1.address;
        w_gByteEnable = m1.byte_enable;
        w_gRead       = m1.read;
        w_gWrite      = m1.write;
        w_gWriteData  = m1.write_data;
      end else begin
        w_gAddress    = m0.address;
        w_gByteEnable = m0.byte_enable;
        w_gRead       = m0.read;
        w_gWrite      = m0.write;
        w_gWriteData  = m0.write_data;
      end
    end
  end

  // A read is held back (not shown to the slave) while the ID FIFO is full.
  // The full test uses the count before any same-cycle pop, which is conservative.
  assign w_rdBlock = w_gRead & (r_rdCnt == CNT_W'(MAX_OUTSTANDING));
  assign w_accept  = w_grantValid & (w_gRead | w_gWrite) & ~s.waitrequest & ~w_rdBlock;

  assign s.address     = w_gAddress;
  assign s.byte_enable = w_gByteEnable;
  assign s.read        = w_gRead & ~w_rdBlock;
  assign s.write       = w_gWrite;
  assign s.write_data  = w_gWriteData;

  assign m0.waitrequest = ~(w_accept & ~w_grant);
  assign m1.waitrequest = ~(w_accept &  w_grant);

  // Response routing: the FIFO head says which master issued the oldest read.
  assign w_cntNonZero = (r_rdCnt != '0);
  assign w_headId     = r_idFifo[r_rdPtr];
  assign w_push       = w_accept & w_gRead;
  assign w_pop        = s.read_data_valid & w_cntNonZero;

  assign m0.read_data       = s.read_data;
  assign m1.read_data       = s.read_data;
  assign m0.read_data_valid = w_pop & ~w_headId;
  assign m1.read_data_valid = w_pop &  w_headId;

  assign err_rvalid_unexp = r_err;

  // Next-state logic: lock onto a stalled command, release once it is accepted.
  always_comb begin
    w_nextState = r_state;
    w_nextOwner = r_owner;
    case (r_state)
      ST_IDLE: begin
        if (w_grantValid && (w_gRead || w_gWrite) && s.waitrequest) begin
          w_nextState = ST_LOCKED;
          w_nextOwner = w_grant;
        end
      end
      ST_LOCKED: begin
        if (w_accept) begin
          w_nextState = ST_IDLE;
        end
      end
      default: begin
        w_nextState = ST_IDLE;
      end
    endcase
  end

  // Grant state register.
  always_ff @(posedge clk) begin
    if (rest) begin
      r_state <= ST_IDLE;
      r_owner <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_owner <= w_nextOwner;
    end
  end

  // ID FIFO pointers and occupancy; a simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge clk) begin
    if (rest) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_rdCnt <= '0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + PTR_W'(1);
      end
      if (w_push && !w_pop) begin
        r_rdCnt <= r_rdCnt + CNT_W'(1);
      end else if (w_pop && !w_push) begin
        r_rdCnt <= r_rdCnt - CNT_W'(1);
      end
    end
  end

  // ID FIFO storage; entries are only read while the count says they are valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_idFifo[r_wrPtr] <= w_grant;
    end
  end

  // Sticky flag for a response that arrives with no read outstanding.
  always_ff @(posedge clk) begin
    if (rest) begin
      r_err <= 1'b0;
    end else if (s.read_data_valid && !w_cntNonZero) begin
      r_err <= 1'b1;
    end
  end

`ifdef CORE_AVL_ARB_RR_EN
  // Round-robin history: remember who got the last accepted command; m0 wins the first tie.
  always_ff @(posedge clk) begin
    if (rest) begin
      r_last <= 1'b1;
    end else if (w_accept) begin
      r_last <= w_grant;
    end
  end
`endif

endmodule

// File: tb/tb_core_avl_arbiter.sv
// Directed self-checking bench for core_avl_arbiter.
// Inputs change on the falling edge and outputs are sampled 1ns later,
// well away from the rising edge where the DUT updates its state.
module tb_core_avl_arbiter;

  logic clk = 1'b0;
  logic rest;
  logic errFlag;
  int   testCount = 0;
  int   failCount = 0;

  core_avl_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m0Bus ();
  core_avl_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m1Bus ();
  core_avl_arbiter_if #(.ADDR_W(32), .DATA_W(32)) sBus ();

  core_avl_arbiter #(
    .ADDR_W(32),
    .DATA_W(32),
    .MAX_OUTSTANDING(4)
  ) dut (
    .clk              (clk),
    .rest             (rest),
    .m0               (m0Bus),
    .m1               (m1Bus),
    .s                (sBus),
    .err_rvalid_unexp (errFlag)
  );

  // Free-running 10ns clock.
  always #5 clk = ~clk;

  // Drive one cycle's worth of inputs at the falling edge, then settle before sampling.
  task automatic applyStimulus(
    input logic        m0Rd,
    input logic        m0Wr,
    input logic [31:0] m0Addr,
    input logic        m1Rd,
    input logic        m1Wr,
    input logic [31:0] m1Addr,
    input logic        sWait,
    input logic        rValid,
    input logic [31:0] rData
  );
    @(negedge clk);
    m0Bus.read            = m0Rd;
    m0Bus.write           = m0Wr;
    m0Bus.address         = m0Addr;
    m0Bus.byte_enable     = 4'h3;
    m0Bus.write_data      = 32'hA0A0_A0A0;
    m1Bus.read            = m1Rd;
    m1Bus.write           = m1Wr;
    m1Bus.address         = m1Addr;
    m1Bus.byte_enable     = 4'hC;
    m1Bus.write_data      = 32'hB1B1_B1B1;
    sBus.waitrequest      = sWait;
    sBus.read_data_valid  = rValid;
    sBus.read_data        = rData;
    #1;
  endtask

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    testCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Directed scenario sequence.
  initial begin
    logic expGrant;

    rest = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("rst_m0_wait", 64'(m0Bus.waitrequest), 64'd1);
    checkOutput("rst_m1_wait", 64'(m1Bus.waitrequest), 64'd1);
    checkOutput("rst_s_read", 64'(sBus.read), 64'd0);
    checkOutput("rst_s_write", 64'(sBus.write), 64'd0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    rest = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("rst_err", 64'(errFlag), 64'd0);

    $display("[TB] single read");
    applyStimulus(1, 0, 32'h1000, 0, 0, 0, 0, 0, 0);
    checkOutput("sr_s_read", 64'(sBus.read), 64'd1);
    checkOutput("sr_s_addr", 64'(sBus.address), 64'h1000);
    checkOutput("sr_s_be", 64'(sBus.byte_enable), 64'h3);
    checkOutput("sr_m0_wait", 64'(m0Bus.waitrequest), 64'd0);
    checkOutput("sr_m1_wait", 64'(m1Bus.waitrequest), 64'd1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 32'hDEAD_BEEF);
    checkOutput("sr_m0_rdv", 64'(m0Bus.read_data_valid), 64'd1);
    checkOutput("sr_m0_rdata", 64'(m0Bus.read_data), 64'hDEAD_BEEF);
    checkOutput("sr_m1_rdv", 64'(m1Bus.read_data_valid), 64'd0);

    $display("[TB] stall lock");
    applyStimulus(0, 0, 0, 1, 0, 32'h200, 1, 0, 0);
    checkOutput("sl_addr_c1", 64'(sBus.address), 64'h200);
    checkOutput("sl_m1_wait_c1", 64'(m1Bus.waitrequest), 64'd1);
    applyStimulus(1, 0, 32'h300, 1, 0, 32'h200, 1, 0, 0);
    checkOutput("sl_addr_c2", 64'(sBus.address), 64'h200);
    checkOutput("sl_m0_wait_c2", 64'(m0Bus.waitrequest), 64'd1);
    applyStimulus(1, 0, 32'h300, 1, 0, 32'h200, 1, 0, 0);
    checkOutput("sl_addr_c3", 64'(sBus.address), 64'h200);
    checkOutput("sl_m0_wait_c3", 64'(m0Bus.waitrequest), 64'd1);
    applyStimulus(1, 0, 32'h300, 1, 0, 32'h200, 0, 0, 0);
    checkOutput("sl_addr_acc", 64'(sBus.address), 64'h200);
    checkOutput("sl_m1_wait_acc", 64'(m1Bus.waitrequest), 64'd0);
    checkOutput("sl_m0_wait_acc", 64'(m0Bus.waitrequest), 64'd1);
    applyStimulus(1, 0, 32'h300, 0, 0, 0, 0, 0, 0);
    checkOutput("sl_m0_addr", 64'(sBus.address), 64'h300);
    checkOutput("sl_m0_wait", 64'(m0Bus.waitrequest), 64'd0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 32'h2222_2222);
    checkOutput("sl_rsp1_m1", 64'(m1Bus.read_data_valid), 64'd1);
    checkOutput("sl_rsp1_m0", 64'(m0Bus.read_data_valid), 64'd0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 32'h3333_3333);
    checkOutput("sl_rsp2_m0", 64'(m0Bus.read_data_valid), 64'd1);
    checkOutput("sl_rsp2_m1", 64'(m1Bus.read_data_valid), 64'd0);

    $display("[TB] outstanding limit");
    for (int k = 0; k < 4; k++) begin
      applyStimulus(0, 0, 0, 1, 0, 32'h400 + 32'(4 * k), 0, 0, 0);
      checkOutput("ol_m1_wait", 64'(m1Bus.waitrequest), 64'd0);
      checkOutput("ol_s_read", 64'(sBus.read), 64'd1);
    end
    applyStimulus(0, 0, 0, 1, 0, 32'h410, 0, 0, 0);
    checkOutput("ol_full_wait", 64'(m1Bus.waitrequest), 64'd1);
    checkOutput("ol_full_s_read", 64'(sBus.read), 64'd0);
    applyStimulus(0, 0, 0, 1, 0, 32'h410, 0, 1, 32'h0000_0040);
    checkOutput("ol_rsp_rdv", 64'(m1Bus.read_data_valid), 64'd1);
    checkOutput("ol_rsp_wait", 64'(m1Bus.waitrequest), 64'd1);
    checkOutput("ol_rsp_s_read", 64'(sBus.read), 64'd0);
    applyStimulus(0, 0, 0, 1, 0, 32'h410, 0, 0, 0);
    checkOutput("ol_fifth_wait", 64'(m1Bus.waitrequest), 64'd0);
    checkOutput("ol_fifth_s_read", 64'(sBus.read), 64'd1);
    checkOutput("ol_fifth_addr", 64'(sBus.address), 64'h410);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 32'h50 + 32'(k));
      checkOutput("ol_drain_m1", 64'(m1Bus.read_data_valid), 64'd1);
      checkOutput("ol_drain_m0", 64'(m0Bus.read_data_valid), 64'd0);
    end

    $display("[TB] interleaved routing");
    applyStimulus(1, 0, 32'h500, 0, 0, 0, 0, 0, 0);
    checkOutput("ir_rd0_wait", 64'(m0Bus.waitrequest), 64'd0);
    applyStimulus(0, 0, 0, 1, 0, 32'h600, 0, 0, 0);
    checkOutput("ir_rd1_wait", 64'(m1Bus.waitrequest), 64'd0);
    applyStimulus(0, 0, 0, 0, 1, 32'h700, 0, 0, 0);
    checkOutput("ir_wr_wait", 64'(m1Bus.waitrequest), 64'd0);
    checkOutput("ir_wr_s_write", 64'(sBus.write), 64'd1);
    checkOutput("ir_wr_data", 64'(sBus.write_data), 64'hB1B1_B1B1);
    applyStimulus(1, 0, 32'h504, 0, 0, 0, 0, 0, 0);
    checkOutput("ir_rd2_wait", 64'(m0Bus.waitrequest), 64'd0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 32'hAAAA_0001);
    checkOutput("ir_A_m0", 64'(m0Bus.read_data_valid), 64'd1);
    checkOutput("ir_A_m1", 64'(m1Bus.read_data_valid), 64'd0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 32'hBBBB_0002);
    checkOutput("ir_B_m1", 64'(m1Bus.read_data_valid), 64'd1);
    checkOutput("ir_B_m0", 64'(m0Bus.read_data_valid), 64'd0);
    checkOutput("ir_B_data", 64'(m1Bus.read_data), 64'hBBBB_0002);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 32'hCCCC_0003);
    checkOutput("ir_C_m0", 64'(m0Bus.read_data_valid), 64'd1);
    checkOutput("ir_C_m1", 64'(m1Bus.read_data_valid), 64'd0);
    checkOutput("ir_C_data", 64'(m0Bus.read_data), 64'hCCCC_0003);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("ir_err_clear", 64'(errFlag), 64'd0);

    $display("[TB] error and reset");
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 32'h0000_000E);
    checkOutput("er_m0_rdv", 64'(m0Bus.read_data_valid), 64'd0);
    checkOutput("er_m1_rdv", 64'(m1Bus.read_data_valid), 64'd0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("er_flag_set", 64'(errFlag), 64'd1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("er_flag_sticky", 64'(errFlag), 64'd1);
    applyStimulus(1, 0, 32'h800, 0, 0, 0, 0, 0, 0);
    checkOutput("er_pre_rst_wait", 64'(m0Bus.waitrequest), 64'd0);
    rest = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    rest = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("er_flag_cleared", 64'(errFlag), 64'd0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 32'h0000_0F0F);
    checkOutput("er_stale_m0_rdv", 64'(m0Bus.read_data_valid), 64'd0);
    checkOutput("er_stale_m1_rdv", 64'(m1Bus.read_data_valid), 64'd0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("er_stale_flag", 64'(errFlag), 64'd1);

    $display("[TB] contention");
    rest = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    rest = 1'b0;
    for (int k = 0; k < 4; k++) begin
      applyStimulus(0, 1, 32'h900, 0, 1, 32'h910, 0, 0, 0);
`ifdef CORE_AVL_ARB_RR_EN
      expGrant = (k % 2) == 1;
`else
      expGrant = 1'b0;
`endif
      checkOutput("ct_m0_wait", 64'(m0Bus.waitrequest), 64'(expGrant));
      checkOutput("ct_m1_wait", 64'(m1Bus.waitrequest), 64'(!expGrant));
      checkOutput("ct_s_addr", 64'(sBus.address), expGrant ? 64'h910 : 64'h900);
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("ct_idle_write", 64'(sBus.write), 64'd0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
